multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Main control FSM for the multi-cycle RV32I core (R-type, lw, sw, beq).
//  Sequences the shared datapath: one memory port, one ALU, IR/ALUOut/MDR registers.
//  Decodes the IR opcode once per instruction and waits on a memory ready handshake.
//  Faults on unsupported opcodes or a memory timeout.
// PARAMETERS
//  TIMEOUT  15  max consecutive mem_ready-low cycles in a wait state before FAULT; 0 = never time out
//  CNT_W    4   width of the wait counter; must satisfy 2^CNT_W > TIMEOUT
// PORTS
//  clk         in   1  single clock; all state changes on the rising edge
//  reset       in   1  synchronous, active-high
//  opcode      in   7  IR[6:0]; stable from DECODE until the next FETCH
//  zero        in   1  ALU zero flag
//  mem_ready   in   1  memory completes the current access this cycle
//  pcWrite     out  1  PC load enable
//  pcSrc       out  1  0 = ALU result (PC+4); 1 = ALUOut (branch target)
//  irWrite     out  1  IR load enable
//  adrSrc      out  1  memory address: 0 = PC, 1 = ALUOut
//  memRead     out  1  memory read request
//  memWrite    out  1  memory write request
//  regWrite    out  1  register file write enable
//  memToReg    out  1  writeback select: 1 = MDR, 0 = ALUOut
//  ALUsrcA     out  2  00 = PC, 01 = oldPC, 10 = rs1
//  ALUsrcB     out  2  00 = rs2, 01 = imm, 10 = constant 4
//  ALUop       out  2  00 = add, 01 = sub (beq), 10 = funct-decoded (R-type)
//  instr_done  out  1  1-cycle pulse on the last cycle of each retired instruction
//  fault       out  1  high while in FAULT
//  state_o     out  4  current state code, for debug
// BEHAVIOUR
//  States and codes:
//   IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6,
//   EXECR=7, ALUWB=8, BEQ=9, FAULT=10.
//  Reset:
//   - reset high -> state=IDLE, counter=0. Next state after reset deasserts is FETCH.
//   - In IDLE, every output is 0 (state_o=0).
//   - reset overrides any state, including mid-wait and FAULT.
//  Output rule: every output not listed for a state below is 0.
//  FETCH: memRead=1, adrSrc=0, ALUsrcA=00, ALUsrcB=10, ALUop=00.
//   irWrite = pcWrite = mem_ready (pcSrc=0).
//   mem_ready -> DECODE; otherwise stay.
//  DECODE: ALUsrcA=01, ALUsrcB=01, ALUop=00 (branch target into ALUOut). Next state by opcode:
//   0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 1100011 -> BEQ; any other -> FAULT.
//  MEMADR: ALUsrcA=10, ALUsrcB=01, ALUop=00.
//   opcode 0000011 -> MEMREAD; otherwise -> MEMWRITE.
//  MEMREAD: adrSrc=1, memRead=1. mem_ready -> MEMWB; otherwise stay.
//  MEMWB: regWrite=1, memToReg=1, instr_done=1 -> FETCH.
//  MEMWRITE: adrSrc=1, memWrite=1, instr_done=mem_ready. mem_ready -> FETCH; otherwise stay.
//  EXECR: ALUsrcA=10, ALUsrcB=00, ALUop=10 -> ALUWB.
//  ALUWB: regWrite=1, memToReg=0, instr_done=1 -> FETCH.
//  BEQ: ALUsrcA=10, ALUsrcB=00, ALUop=01, pcSrc=1, pcWrite=zero, instr_done=1 -> FETCH.
//  FAULT: fault=1, all strobes 0. Stays in FAULT until reset.
//  Cycles per instruction with zero-wait memory:
//   R-type 4, lw 5, sw 4, beq 3.
//   Each mem_ready-low cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
//  Wait counter:
//   - Cleared on entry to any state.
//   - Increments (saturating) each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
//   - Timeout: TIMEOUT!=0, counter==TIMEOUT-1 and mem_ready=0 -> next state FAULT.
//     memRead/memWrite drop when FAULT is entered.
//   - mem_ready=1 on the timeout cycle wins: normal transition, no fault.
//  Mealy outputs:
//   - pcWrite and irWrite in FETCH, pcWrite in BEQ, instr_done in MEMWRITE.
//   - All other outputs are decoded from the state only.
// TESTING
//  1. reset 3 cycles, opcode=0110011, mem_ready=1 -> states 0,1,2,7,8,1.
//     regWrite=1 only in ALUWB; instr_done pulses once; 4 cycles per instruction.
//  2. lw (0000011), mem_ready low 2 cycles in MEMREAD -> MEMREAD held 3 cycles, then MEMWB.
//     MEMWB drives regWrite=1, memToReg=1; 7 cycles total.
//  3. beq (1100011): zero=1 -> pcWrite=1, pcSrc=1 in BEQ.
//     Repeat with zero=0 -> pcWrite=0; both back to FETCH after 3 cycles.
//  4. opcode=0010011 in DECODE -> FAULT (state_o=10), fault=1, all strobes 0.
//     Held there 10 cycles; reset returns to IDLE then FETCH.
//  5. TIMEOUT=15, mem_ready=0 forever in FETCH -> fault after exactly 15 FETCH cycles.
//     Repeat with mem_ready=1 on cycle 15 -> DECODE, no fault.
//  6. sw (0100011) with reset asserted in MEMWRITE -> memWrite=0 and state IDLE next cycle.
//     Then a normal fetch follows.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for a multi-cycle RV32I core (R-type, lw, sw, beq) sharing one
// memory port and one ALU; waits on a memory ready handshake and faults on bad opcodes or timeouts.
module multicycle_controller #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcWrite,
    output logic       pcSrc,
    output logic       irWrite,
    output logic       adrSrc,
    output logic       memRead,
    output logic       memWrite,
    output logic       regWrite,
    output logic       memToReg,
    output logic [1:0] ALUsrcA,
    output logic [1:0] ALUsrcB,
    output logic [1:0] ALUop,
    output logic       instr_done,
    output logic       fault,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_FAULT    = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wait_state;
    logic               stalled;
    logic               timeout_hit;

    // Only the three memory-facing states can stall on mem_ready.
    assign wait_state  = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                         (state_q == S_MEMWRITE);
    assign stalled     = wait_state && !mem_ready;
    assign timeout_hit = (TIMEOUT != 0) && stalled && (cnt_q == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: next-state and counter get defaults first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)        state_d = S_DECODE;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FAULT;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (mem_ready)        state_d = S_MEMWB;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready)        state_d = S_FETCH;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_EXECR:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_FAULT;
        endcase

        // Counter restarts on every state entry and saturates rather than wrapping.
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (stalled && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        pcWrite    = 1'b0;
        pcSrc      = 1'b0;
        irWrite    = 1'b0;
        adrSrc     = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        regWrite   = 1'b0;
        memToReg   = 1'b0;
        ALUsrcA    = SRCA_PC;
        ALUsrcB    = SRCB_RS2;
        ALUop      = ALU_ADD;
        instr_done = 1'b0;
        fault      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                ALUsrcB = SRCB_FOUR;
                irWrite = mem_ready;
                pcWrite = mem_ready;
            end
            S_DECODE: begin
                ALUsrcA = SRCA_OLDPC;
                ALUsrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUsrcA = SRCA_RS1;
                ALUsrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                adrSrc  = 1'b1;
                memRead = 1'b1;
            end
            S_MEMWB: begin
                regWrite   = 1'b1;
                memToReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc     = 1'b1;
                memWrite   = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECR: begin
                ALUsrcA = SRCA_RS1;
                ALUop   = ALU_FUNCT;
            end
            S_ALUWB: begin
                regWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                ALUsrcA    = SRCA_RS1;
                ALUop      = ALU_SUB;
                pcSrc      = 1'b1;
                pcWrite    = zero;
                instr_done = 1'b1;
            end
            S_FAULT:    fault = 1'b1;
            default:    ;
        endcase
    end

    assign state_o = state_q;

endmodule
